// File: rtl/hififo_pkg.sv
// Shared sizes, PIO register map and FSM encoding for the FPGA-to-host
// streaming FIFO.
package hififo_pkg;

  localparam int unsigned BLOCK_QW   = 16;
  localparam int unsigned BUF_QW     = 512;
  localparam int unsigned PT_ENTRIES = 32;
  localparam int unsigned PAGE_BITS  = 21;
  localparam int unsigned PTR_BITS   = 19;
  localparam int unsigned PT_BITS    = 64 - PAGE_BITS;

  localparam logic [7:0]  PIO_PT_TPC   = 8'd3;
  localparam logic [12:0] PIO_STOP_TPC = 13'd8;
  localparam logic [12:0] PIO_INT_TPC  = 13'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/sdp_bram_64x512.sv
// Simple dual-port 64x512 RAM with a registered read port; the read
// register clears on reset so the beat output starts at zero.
module sdp_bram_64x512 (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_en,
  input  logic [8:0]  i_wr_addr,
  input  logic [63:0] i_wr_data,
  input  logic        i_rd_en,
  input  logic [8:0]  i_rd_addr,
  output logic [63:0] o_rd_data
);

  logic [63:0] r_mem [0:511];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)        o_rd_data <= '0;
    else if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/pcie_to_pc_fifo.sv
// FPGA-to-host streaming FIFO: buffers 64-bit words and issues one PCIe
// memory write per 128-byte block into a page-table-described host ring.
module pcie_to_pc_fifo
  import hififo_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  output logic [1:0]  interrupt,
  output logic [63:0] status,
  input  logic        pio_wvalid,
  input  logic [63:0] pio_wdata,
  input  logic [12:0] pio_addr,
  input  logic        fifo_write,
  input  logic [63:0] fifo_write_data,
  output logic        fifo_ready,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [63:0] wr_addr,
  input  logic        wr_data_read,
  output logic [63:0] wr_data
);

  logic [PT_BITS-1:0]  r_pt [0:PT_ENTRIES-1];
  logic [PT_BITS-1:0]  r_pt_q;
  logic [PTR_BITS-1:0] r_p_stop;
  logic [PTR_BITS-1:0] r_p_int;
  logic [PTR_BITS-1:0] r_p_sent;
  logic [9:0]          r_p_in;
  logic [3:0]          r_beat;
  logic [1:0]          r_interrupt;
  fsm_state_t          r_state;

  logic [9:0] w_occ;
  logic       w_push;
  logic       w_pop;
  logic       w_last_beat;
  logic       w_unused;

  // Occupancy in qwords; p_sent is scaled to qwords and both wrap at 1024.
  assign w_occ       = r_p_in - {r_p_sent[5:0], 4'd0};
  assign fifo_ready  = (w_occ != 10'(BUF_QW));
  assign w_push      = fifo_write & fifo_ready;
  assign w_pop       = (r_state == ST_DATA) & wr_data_read;
  assign w_last_beat = w_pop & (r_beat == 4'(BLOCK_QW - 1));
  assign w_unused    = ^pio_wdata[6:0];

  assign wr_valid  = (r_state == ST_REQ);
  assign wr_addr   = {r_pt_q, r_p_sent[13:0], 7'd0};
  assign status    = {38'd0, r_p_sent, 7'd0};
  assign interrupt = r_interrupt;

  // Page table is not reset; pt_q follows p_sent one cycle late, which the
  // mandatory IDLE cycle before REQ absorbs.
  always_ff @(posedge clock) begin
    if (pio_wvalid && (pio_addr[12:5] == PIO_PT_TPC))
      r_pt[pio_addr[4:0]] <= pio_wdata[63:PAGE_BITS];
    r_pt_q <= r_pt[r_p_sent[18:14]];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_p_stop <= '0;
      r_p_int  <= '0;
    end else if (pio_wvalid) begin
      if (pio_addr == PIO_STOP_TPC) r_p_stop <= pio_wdata[25:7];
      if (pio_addr == PIO_INT_TPC)  r_p_int  <= pio_wdata[25:7];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_p_in      <= '0;
      r_p_sent    <= '0;
      r_beat      <= '0;
      r_interrupt <= 2'b11;
    end else begin
      if (w_push) r_p_in <= r_p_in + 10'd1;
      r_interrupt <= {r_p_stop == r_p_sent, r_p_int == r_p_sent};
      case (r_state)
        ST_IDLE: begin
          if ((w_occ >= 10'(BLOCK_QW)) && (r_p_sent != r_p_stop))
            r_state <= ST_REQ;
        end
        ST_REQ: begin
          if (wr_ready) begin
            r_state <= ST_DATA;
            r_beat  <= '0;
          end
        end
        ST_DATA: begin
          if (w_pop) begin
            r_beat <= r_beat + 4'd1;
            if (w_last_beat) begin
              r_p_sent <= r_p_sent + 19'd1;
              r_state  <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sdp_bram_64x512 u_bram (
    .i_clk     (clock),
    .i_rst     (reset),
    .i_wr_en   (w_push),
    .i_wr_addr (r_p_in[8:0]),
    .i_wr_data (fifo_write_data),
    .i_rd_en   (w_pop),
    .i_rd_addr ({r_p_sent[4:0], r_beat}),
    .o_rd_data (wr_data)
  );

endmodule

// File: tb/tb_pcie_to_pc_fifo.sv
// Scoreboard bench for pcie_to_pc_fifo: stimulus queues expected request
// addresses and beats; a TLP-engine model pops and compares them.
module tb_pcie_to_pc_fifo;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  interrupt;
  logic [63:0] status;
  logic        pio_wvalid = 1'b0;
  logic [63:0] pio_wdata = '0;
  logic [12:0] pio_addr = '0;
  logic        fifo_write = 1'b0;
  logic [63:0] fifo_write_data = '0;
  logic        fifo_ready;
  logic        wr_valid;
  logic        wr_ready;
  logic [63:0] wr_addr;
  logic        wr_data_read;
  logic [63:0] wr_data;

  logic eng_ready = 1'b0, stim_ready = 1'b0;
  logic eng_read = 1'b0, stim_read = 1'b0;
  assign wr_ready     = eng_ready | stim_ready;
  assign wr_data_read = eng_read | stim_read;

  logic [63:0] exp_addr_q[$];
  logic [63:0] exp_data_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int exp_sent = 0;
  bit eng_en = 1'b0;
  int eng_stall = 0;
  bit eng_gap = 1'b0;

  localparam logic [63:0] PT0 = 64'h1_0000_0000;

  always #5 clock = ~clock;

  pcie_to_pc_fifo dut (
    .clock(clock), .reset(reset), .interrupt(interrupt), .status(status),
    .pio_wvalid(pio_wvalid), .pio_wdata(pio_wdata), .pio_addr(pio_addr),
    .fifo_write(fifo_write), .fifo_write_data(fifo_write_data),
    .fifo_ready(fifo_ready), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data_read(wr_data_read), .wr_data(wr_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] blk_word(input int b, input int i);
    return 64'hA5A5_0000_0000_0000 | (64'(b) << 8) | 64'(i);
  endfunction

  function automatic logic [63:0] sent_status(input int s);
    return {38'd0, 19'(s), 7'd0};
  endfunction

  // TLP engine model: accepts requests, pulls beats, checks against scoreboard.
  initial begin
    int gap;
    forever begin
      @(negedge clock);
      if (eng_en && wr_valid) begin
        if (exp_addr_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_req: got addr 0x%0h expected no request", wr_addr);
        end else chk("wr_addr", wr_addr, exp_addr_q.pop_front());
        repeat (eng_stall) begin
          @(negedge clock);
          chk("valid_held", 64'(wr_valid), 64'd1);
          chk("stall_status", status, sent_status(exp_sent));
        end
        eng_ready = 1'b1;
        @(negedge clock);
        eng_ready = 1'b0;
        chk("valid_drop", 64'(wr_valid), 64'd0);
        for (int b = 0; b < 16; b++) begin
          if (eng_gap) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clock);
          end
          eng_read = 1'b1;
          @(negedge clock);
          eng_read = 1'b0;
          if (exp_data_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_beat: got 0x%0h expected no beat", wr_data);
          end else chk("wr_data", wr_data, exp_data_q.pop_front());
          if (b < 15) chk("status_hold", status, sent_status(exp_sent));
        end
        exp_sent++;
        chk("status_adv", status, sent_status(exp_sent));
      end
    end
  end

  task automatic pio(input logic [12:0] a, input logic [63:0] d);
    pio_addr = a; pio_wdata = d; pio_wvalid = 1'b1;
    @(negedge clock);
    pio_wvalid = 1'b0;
  endtask

  task automatic push(input logic [63:0] d, input bit will_send);
    fifo_write = 1'b1; fifo_write_data = d;
    if (will_send) exp_data_q.push_back(d);
    @(negedge clock);
    fifo_write = 1'b0;
  endtask

  task automatic push_block(input int b, input logic [63:0] addr);
    exp_addr_q.push_back(addr);
    for (int i = 0; i < 16; i++) push(blk_word(b, i), 1'b1);
  endtask

  task automatic wait_status(input logic [63:0] target, input string name);
    int t = 0;
    while (status !== target && t < 3000) begin
      @(negedge clock);
      t++;
    end
    chk(name, status, target);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    exp_sent = 0;
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int t;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_valid", 64'(wr_valid), 64'd0);
    chk("rst_status", status, 64'd0);
    chk("rst_ready", 64'(fifo_ready), 64'd1);
    chk("rst_int", 64'(interrupt), 64'd3);
    chk("rst_wr_data", wr_data, 64'd0);

    // Single block with request latency
    pio(13'h60, PT0);
    pio(13'd8, 64'h80);
    @(negedge clock);
    chk("int_after_stop", 64'(interrupt), 64'd1);
    eng_en = 1'b1;
    exp_addr_q.push_back(PT0);
    for (int i = 0; i < 16; i++) push(64'(i), 1'b1);
    chk("req_early", 64'(wr_valid), 64'd0);
    @(negedge clock);
    chk("req_latency", 64'(wr_valid), 64'd1);
    wait_status(64'h80, "status_blk0");
    @(negedge clock);
    chk("int_stop", 64'(interrupt), 64'd2);

    // Interrupt threshold, back-to-back blocks
    pio(13'd9, 64'h180);
    pio(13'd8, 64'h280);
    push_block(1, PT0 + 64'h80);
    push_block(2, PT0 + 64'h100);
    wait_status(64'h180, "status_blk2");
    chk("int0_not_yet", 64'(interrupt), 64'd0);
    @(negedge clock);
    chk("int0_rise", 64'(interrupt), 64'd1);

    // Stalled accept and gapped beats
    eng_stall = 10; eng_gap = 1'b1;
    push_block(3, PT0 + 64'h180);
    wait_status(64'h200, "status_blk3");
    @(negedge clock);
    chk("int0_clear", 64'(interrupt), 64'd0);
    eng_stall = 0; eng_gap = 1'b0;

    // Stop condition, stray handshakes, resume
    pio(13'd8, 64'h200);
    push_block(4, PT0 + 64'h200);
    repeat (20) @(negedge clock);
    chk("stop_valid", 64'(wr_valid), 64'd0);
    chk("stop_status", status, 64'h200);
    chk("stop_int", 64'(interrupt), 64'd2);
    stim_ready = 1'b1; stim_read = 1'b1;
    @(negedge clock);
    stim_ready = 1'b0; stim_read = 1'b0;
    @(negedge clock);
    chk("stray_valid", 64'(wr_valid), 64'd0);
    chk("stray_read", wr_data, blk_word(3, 15));
    pio(13'd8, 64'h300);
    chk("resume_early", 64'(wr_valid), 64'd0);
    @(negedge clock);
    chk("resume_latency", 64'(wr_valid), 64'd1);
    wait_status(64'h280, "status_blk4");

    // Full buffer
    do_reset();
    accepted = 0;
    for (int i = 0; i < 520; i++) begin
      if (fifo_ready) accepted++;
      push(64'hB000_0000_0000_0000 | 64'(i), i < 16);
      if (i == 510) chk("ready_511", 64'(fifo_ready), 64'd1);
      if (i == 511) chk("ready_512", 64'(fifo_ready), 64'd0);
    end
    chk("accepted", 64'(accepted), 64'd512);
    chk("full_ready", 64'(fifo_ready), 64'd0);
    exp_addr_q.push_back(PT0);
    pio(13'd8, 64'h80);
    wait_status(64'h80, "full_drain");
    chk("ready_freed", 64'(fifo_ready), 64'd1);
    for (int i = 0; i < 15; i++) push(64'hC000 | 64'(i), 1'b0);
    chk("ready_511_again", 64'(fifo_ready), 64'd1);
    push(64'hC0FF, 1'b0);
    chk("p_in_kept", 64'(fifo_ready), 64'd0);

    // Reset mid-burst
    do_reset();
    eng_en = 1'b0;
    pio(13'd8, 64'h80);
    for (int i = 0; i < 16; i++) push(64'hC0 + 64'(i), 1'b0);
    t = 0;
    while (!wr_valid && t < 20) begin
      @(negedge clock);
      t++;
    end
    chk("mb_req", 64'(wr_valid), 64'd1);
    stim_ready = 1'b1;
    @(negedge clock);
    stim_ready = 1'b0;
    for (int b = 0; b < 7; b++) begin
      stim_read = 1'b1;
      @(negedge clock);
      stim_read = 1'b0;
      chk("mb_beat", wr_data, 64'hC0 + 64'(b));
    end
    reset = 1'b1; stim_read = 1'b1;
    @(negedge clock);
    stim_read = 1'b0;
    chk("mb_valid", 64'(wr_valid), 64'd0);
    chk("mb_status", status, 64'd0);
    chk("mb_ready", 64'(fifo_ready), 64'd1);
    chk("mb_wr_data", wr_data, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    eng_en = 1'b1;
    pio(13'd8, 64'h80);
    push_block(9, PT0);
    wait_status(64'h80, "post_reset_blk");

    repeat (5) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
